pixie_dma_scheduler: RTL and testbench

Sequences the CDP1861-style Pixie display for the Studio II core. It runs the line and frame timing on 1802 machine cycles and issues the per-line DMA-out burst to the CPU. It tracks DMA and interrupt acknowledges from the state code (SC) and produces the VRAM fetch address, byte strobes, INT and EF. It sits between the CDP1802 core and the pixel/line-buffer datapath, which consumes `dma_strobe`/`dma_byte_idx` and the byte on the CPU data bus.

---
 rtl/pixie_dma_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pixie_dma_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dma_scheduler.sv
// CDP1861-style Pixie line/frame sequencer and per-line DMA-out burst controller.
// Optional macro PIXIE_DMA_TIMEOUT_EN: abort unfinished bursts at end of line and flag dma_missed.
module pixie_dma_scheduler #(
  parameter int          CYCLES_PER_LINE = 14,
  parameter int          LINES_PER_FRAME = 262,
  parameter int          ACTIVE_START    = 64,
  parameter int          ACTIVE_LINES    = 128,
  parameter int          INT_LINE        = 62,
  parameter int          BYTES_PER_LINE  = 8,
  parameter logic [15:0] START_ADDR      = 16'h0900,
  parameter int          DMA_REQ_CYCLE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  SC,
  input  logic        disp_on,
  input  logic        disp_off,
  output logic        dma_out_n,
  output logic        int_out,
  output logic        efx_n,
  output logic [15:0] dma_addr,
  output logic        dma_strobe,
  output logic [2:0]  dma_byte_idx,
  output logic        line_start,
  output logic        frame_start,
  output logic [6:0]  active_line,
  output logic        display_enabled
`ifdef PIXIE_DMA_TIMEOUT_EN
  ,
  output logic        dma_missed
`endif
);

  localparam int CW = $clog2(CYCLES_PER_LINE);
  localparam int LW = $clog2(LINES_PER_FRAME);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_LINE - 1);
  localparam logic [CW-1:0] CYC_REQ   = CW'(DMA_REQ_CYCLE);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);
  localparam logic [LW-1:0] ACT_FIRST = LW'(ACTIVE_START);
  localparam logic [LW-1:0] ACT_LAST  = LW'(ACTIVE_START + ACTIVE_LINES - 1);
  localparam logic [LW-1:0] INT_FIRST = LW'(INT_LINE);
  localparam logic [LW-1:0] INT_LAST  = LW'(INT_LINE + 1);
  localparam logic [LW-1:0] EF1_FIRST = LW'(ACTIVE_START - 4);
  localparam logic [LW-1:0] EF1_LAST  = LW'(ACTIVE_START - 1);
  localparam logic [LW-1:0] EF2_FIRST = LW'(ACTIVE_START + ACTIVE_LINES - 4);
  localparam logic [2:0]    BYTE_LAST = 3'(BYTES_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cycle_cnt, cyc_nx;
  logic [LW-1:0]   line_cnt, line_nx;
  logic [2:0]      bcnt, bcnt_nx;
  logic [4:0]      row, row_nx;
  logic            int_acked, iack_nx, win_nx;
  logic            en_nx, act_nx;
  logic [6:0]      al_nx;
  logic            strobe_nx;
  logic [15:0]     addr_nx;
  logic [2:0]      idx_nx;
`ifdef PIXIE_DMA_TIMEOUT_EN
  logic            timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset)           state <= S_IDLE;
    else if (clk_enable) state <= state_nx;
  end

  always_comb begin
    cyc_nx  = cycle_cnt + 1'b1;
    line_nx = line_cnt;
    if (cycle_cnt == CYC_LAST) begin
      cyc_nx  = '0;
      line_nx = (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
    end
    en_nx  = disp_off ? 1'b0 : (disp_on ? 1'b1 : display_enabled);
    act_nx = (line_nx >= ACT_FIRST) && (line_nx <= ACT_LAST);
    al_nx  = act_nx ? 7'(line_nx - ACT_FIRST) : 7'd0;

    state_nx  = state;
    bcnt_nx   = bcnt;
    row_nx    = row;
    strobe_nx = 1'b0;
    addr_nx   = dma_addr;
    idx_nx    = dma_byte_idx;
`ifdef PIXIE_DMA_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    // Disable wins over everything, including an acknowledge on the same cycle.
    if (!en_nx) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE: state_nx = S_WAIT;
        S_WAIT: if (act_nx && cyc_nx == CYC_REQ) begin
          state_nx = S_REQ;
          bcnt_nx  = '0;
          row_nx   = al_nx[6:2];  // each row is fetched on 4 consecutive lines
        end
        S_REQ: begin
          if (SC == 2'b10) begin
            strobe_nx = 1'b1;
            addr_nx   = START_ADDR + {8'h00, row, bcnt};
            idx_nx    = bcnt;
            bcnt_nx   = bcnt + 1'b1;
            if (bcnt == BYTE_LAST) state_nx = S_DONE;
          end
`ifdef PIXIE_DMA_TIMEOUT_EN
          if (state_nx == S_REQ && cyc_nx == CYC_LAST) begin
            state_nx = S_DONE;
            timeout  = 1'b1;
          end
`endif
        end
        S_DONE: if (cyc_nx == '0) state_nx = S_WAIT;
        default: state_nx = S_IDLE;
      endcase
    end

    win_nx  = (line_nx == INT_FIRST) || (line_nx == INT_LAST);
    // An interrupt acknowledge only counts while INT is actually being asserted.
    iack_nx = win_nx && (int_acked || (SC == 2'b11 && int_out));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt       <= '0;
      line_cnt        <= '0;
      bcnt            <= '0;
      row             <= '0;
      int_acked       <= 1'b0;
      dma_out_n       <= 1'b1;
      int_out         <= 1'b0;
      efx_n           <= 1'b1;
      dma_addr        <= START_ADDR;
      dma_strobe      <= 1'b0;
      dma_byte_idx    <= '0;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
      active_line     <= '0;
      display_enabled <= 1'b0;
`ifdef PIXIE_DMA_TIMEOUT_EN
      dma_missed      <= 1'b0;
`endif
    end else begin
      dma_strobe  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (clk_enable) begin
        cycle_cnt       <= cyc_nx;
        line_cnt        <= line_nx;
        bcnt            <= bcnt_nx;
        row             <= row_nx;
        int_acked       <= iack_nx;
        dma_out_n       <= (state_nx != S_REQ);
        int_out         <= en_nx && win_nx && !iack_nx;
        efx_n           <= !(((line_nx >= EF1_FIRST) && (line_nx <= EF1_LAST)) ||
                             ((line_nx >= EF2_FIRST) && (line_nx <= ACT_LAST)));
        dma_addr        <= addr_nx;
        dma_strobe      <= strobe_nx;
        dma_byte_idx    <= idx_nx;
        line_start      <= (cyc_nx == '0);
        frame_start     <= (cyc_nx == '0) && (line_nx == '0);
        active_line     <= al_nx;
        display_enabled <= en_nx;
`ifdef PIXIE_DMA_TIMEOUT_EN
        if ((cyc_nx == '0) && (line_nx == '0)) dma_missed <= 1'b0;
        else if (timeout)                      dma_missed <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Bench for pixie_dma_scheduler: acts as the 1802 (acknowledging DMA requests) and
// scoreboards every expected DMA byte against the strobes the scheduler produces.
module tb_pixie_dma_scheduler;

  logic        clk = 1'b0;
  logic        reset, clk_enable, disp_on, disp_off;
  logic [1:0]  SC;
  logic        dma_out_n, int_out, efx_n, dma_strobe, line_start, frame_start, display_enabled;
  logic [15:0] dma_addr;
  logic [2:0]  dma_byte_idx;
  logic [6:0]  active_line;
`ifdef PIXIE_DMA_TIMEOUT_EN
  logic        dma_missed;
`endif

  pixie_dma_scheduler dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .SC(SC),
    .disp_on(disp_on), .disp_off(disp_off),
    .dma_out_n(dma_out_n), .int_out(int_out), .efx_n(efx_n),
    .dma_addr(dma_addr), .dma_strobe(dma_strobe), .dma_byte_idx(dma_byte_idx),
    .line_start(line_start), .frame_start(frame_start),
    .active_line(active_line), .display_enabled(display_enabled)
`ifdef PIXIE_DMA_TIMEOUT_EN
    , .dma_missed(dma_missed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         line;
    logic       ef_n;
    logic       irq;
    logic       req_n;
    logic [6:0] al;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  idx;
  } exp_t;

  vec_t vt[12];
  exp_t sbq[$];

  int checks = 0, errors = 0;
  int cur_cyc = 0, cur_line = 0;
  int bidx = 0, burst_row = 0, ack_budget = -1, nstrobe = 0;
  bit prev_pulse = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (line %0d cycle %0d)", name, got, exp, cur_line, cur_cyc);
    end
  endtask

  // One 1802 machine cycle: clk_enable high for one clk, then one idle clk.
  task automatic mc(input bit force_sc, input logic [1:0] sc_f, input bit on, input bit off);
    logic [1:0] sc;
    exp_t e;
    @(negedge clk);
    if (prev_pulse) begin
      chk("pulse_width", {29'd0, dma_strobe, line_start, frame_start}, 32'd0);
      prev_pulse = 0;
    end
    if (force_sc) sc = sc_f;
    else if (!dma_out_n && ack_budget != 0) begin
      sc = 2'b10;
      if (ack_budget > 0) ack_budget--;
    end else sc = 2'b00;
    if (sc == 2'b10 && !dma_out_n && !off) begin
      if (bidx == 0) burst_row = (cur_line - 64) >> 2;
      e.addr = 16'h0900 + 16'(burst_row * 8 + bidx);
      e.idx  = 3'(bidx);
      sbq.push_back(e);
      bidx = (bidx == 7) ? 0 : bidx + 1;
    end
    SC = sc; disp_on = on; disp_off = off; clk_enable = 1'b1;
    @(negedge clk);
    clk_enable = 1'b0; disp_on = 1'b0; disp_off = 1'b0; SC = 2'b00;
    if (cur_cyc == 13) begin
      cur_cyc  = 0;
      cur_line = (cur_line == 261) ? 0 : cur_line + 1;
    end else cur_cyc++;
    if (dma_strobe) begin
      nstrobe++;
      if (sbq.size() == 0) chk("unexpected_strobe", {31'd0, dma_strobe}, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("dma_addr", {16'd0, dma_addr}, {16'd0, e.addr});
        chk("dma_byte_idx", {29'd0, dma_byte_idx}, {29'd0, e.idx});
      end
    end else if (sbq.size() != 0) begin
      chk("missing_strobe", {31'd0, dma_strobe}, 32'd1);
      sbq.delete();
    end
    chk("line_start", {31'd0, line_start}, {31'd0, cur_cyc == 0});
    chk("frame_start", {31'd0, frame_start}, {31'd0, cur_cyc == 0 && cur_line == 0});
    if (dma_strobe || line_start || frame_start) prev_pulse = 1;
  endtask

  task automatic run_to(input int line, input int cyc);
    int n = 0;
    while (!(cur_line == line && cur_cyc == cyc)) begin
      mc(1'b0, 2'b00, 1'b0, 1'b0);
      n++;
      if (n > 262 * 14 + 2) begin
        chk("run_to_bound", cur_line * 100 + cur_cyc, line * 100 + cyc);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // line, efx_n, int_out, dma_out_n, active_line -- display disabled all frame
    vt[0]  = '{59,  1'b1, 1'b0, 1'b1, 7'd0};
    vt[1]  = '{60,  1'b0, 1'b0, 1'b1, 7'd0};
    vt[2]  = '{62,  1'b0, 1'b0, 1'b1, 7'd0};
    vt[3]  = '{63,  1'b0, 1'b0, 1'b1, 7'd0};
    vt[4]  = '{64,  1'b1, 1'b0, 1'b1, 7'd0};
    vt[5]  = '{65,  1'b1, 1'b0, 1'b1, 7'd1};
    vt[6]  = '{127, 1'b1, 1'b0, 1'b1, 7'd63};
    vt[7]  = '{187, 1'b1, 1'b0, 1'b1, 7'd123};
    vt[8]  = '{188, 1'b0, 1'b0, 1'b1, 7'd124};
    vt[9]  = '{191, 1'b0, 1'b0, 1'b1, 7'd127};
    vt[10] = '{192, 1'b1, 1'b0, 1'b1, 7'd0};
    vt[11] = '{261, 1'b1, 1'b0, 1'b1, 7'd0};

    reset = 1'b1; clk_enable = 1'b0; disp_on = 1'b0; disp_off = 1'b0; SC = 2'b00;
    repeat (2) @(negedge clk);
    clk_enable = 1'b1;
    @(negedge clk);
    clk_enable = 1'b0; reset = 1'b0;
    chk("rst_dma_out_n", {31'd0, dma_out_n}, 32'd1);
    chk("rst_int_out", {31'd0, int_out}, 32'd0);
    chk("rst_efx_n", {31'd0, efx_n}, 32'd1);
    chk("rst_dma_addr", {16'd0, dma_addr}, 32'h0900);
    chk("rst_dma_strobe", {31'd0, dma_strobe}, 32'd0);
    chk("rst_byte_idx", {29'd0, dma_byte_idx}, 32'd0);
    chk("rst_line_start", {31'd0, line_start}, 32'd0);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
    chk("rst_active_line", {25'd0, active_line}, 32'd0);
    chk("rst_enabled", {31'd0, display_enabled}, 32'd0);
`ifdef PIXIE_DMA_TIMEOUT_EN
    chk("rst_dma_missed", {31'd0, dma_missed}, 32'd0);
`endif

    // Disabled frame, table-driven
    for (int i = 0; i < 12; i++) begin
      run_to(vt[i].line, 0);
      chk("dis_efx_n", {31'd0, efx_n}, {31'd0, vt[i].ef_n});
      chk("dis_int_out", {31'd0, int_out}, {31'd0, vt[i].irq});
      chk("dis_dma_out_n", {31'd0, dma_out_n}, {31'd0, vt[i].req_n});
      chk("dis_active_line", {25'd0, active_line}, {25'd0, vt[i].al});
    end
    run_to(0, 0);

    // Enable, full acknowledges, unacknowledged INT window
    mc(1'b0, 2'b00, 1'b1, 1'b0);
    chk("en_on", {31'd0, display_enabled}, 32'd1);
    run_to(61, 13); chk("int_61", {31'd0, int_out}, 32'd0);
    mc(1'b0, 2'b00, 1'b0, 1'b0); chk("int_62", {31'd0, int_out}, 32'd1);
    run_to(63, 13); chk("int_63", {31'd0, int_out}, 32'd1);
    nstrobe = 0;
    mc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("int_64", {31'd0, int_out}, 32'd0);
    chk("efx_64", {31'd0, efx_n}, 32'd1);
    mc(1'b0, 2'b00, 1'b0, 1'b0); chk("req_64_c1", {31'd0, dma_out_n}, 32'd0);
    run_to(64, 8); chk("req_64_c8", {31'd0, dma_out_n}, 32'd0);
    mc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("req_64_c9", {31'd0, dma_out_n}, 32'd1);
    chk("strobes_64", nstrobe, 32'd8);
    run_to(68, 1); chk("al_68", {25'd0, active_line}, 32'd4);
    run_to(69, 0); chk("strobes_64_68", nstrobe, 32'd40);

    // INT acknowledge in the next frame
    run_to(62, 5); chk("int_pre_ack", {31'd0, int_out}, 32'd1);
    mc(1'b1, 2'b11, 1'b0, 1'b0); chk("int_acked", {31'd0, int_out}, 32'd0);
    run_to(63, 0);  chk("int_acked_63", {31'd0, int_out}, 32'd0);
    run_to(63, 13); chk("int_acked_63e", {31'd0, int_out}, 32'd0);

    // disp_off after 3 acknowledges of the line 70 burst
    run_to(70, 1); nstrobe = 0;
    run_to(70, 4); chk("abort_pre", nstrobe, 32'd3);
    mc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("abort_req_n", {31'd0, dma_out_n}, 32'd1);
    chk("abort_en", {31'd0, display_enabled}, 32'd0);
    bidx = 0;
    run_to(72, 5); chk("abort_nomore", nstrobe, 32'd3);

    // Mid-frame enable waits for the next line's request cycle
    mc(1'b0, 2'b00, 1'b1, 1'b0); chk("midon_en", {31'd0, display_enabled}, 32'd1);
    run_to(72, 9);  chk("midon_72", {31'd0, dma_out_n}, 32'd1);
    run_to(73, 1);  chk("midon_73", {31'd0, dma_out_n}, 32'd0);
    run_to(73, 12);
    mc(1'b0, 2'b00, 1'b1, 1'b1); chk("on_off_both", {31'd0, display_enabled}, 32'd0);

    // Short burst: only 5 acknowledges on line 64
    run_to(0, 0);
    mc(1'b0, 2'b00, 1'b1, 1'b0);
    run_to(64, 0); nstrobe = 0; ack_budget = 5;
    run_to(64, 12);
    chk("short_req_c12", {31'd0, dma_out_n}, 32'd0);
    chk("short_strobes", nstrobe, 32'd5);
    mc(1'b0, 2'b00, 1'b0, 1'b0);
`ifdef PIXIE_DMA_TIMEOUT_EN
    chk("timeout_req_n", {31'd0, dma_out_n}, 32'd1);
    chk("timeout_missed", {31'd0, dma_missed}, 32'd1);
    bidx = 0; ack_budget = -1;
    run_to(100, 0); chk("missed_sticky", {31'd0, dma_missed}, 32'd1);
    run_to(0, 0);   chk("missed_clear", {31'd0, dma_missed}, 32'd0);
`else
    chk("hold_req_n", {31'd0, dma_out_n}, 32'd0);
    ack_budget = -1;
    run_to(65, 3);
    chk("hold_done", {31'd0, dma_out_n}, 32'd1);
    chk("hold_strobes", nstrobe, 32'd8);
`endif

    // Reset in the middle of a burst, with clk_enable low
    run_to(66, 4); chk("pre_reset_req", {31'd0, dma_out_n}, 32'd0);
    @(negedge clk); reset = 1'b1; clk_enable = 1'b0;
    @(negedge clk); reset = 1'b0;
    chk("midrst_req_n", {31'd0, dma_out_n}, 32'd1);
    chk("midrst_en", {31'd0, display_enabled}, 32'd0);
    chk("midrst_addr", {16'd0, dma_addr}, 32'h0900);
    chk("midrst_idx", {29'd0, dma_byte_idx}, 32'd0);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
